// File: rtl/jam_pkg.sv
// jam_pkg: FSM encoding, width helpers and permutation utilities shared by jam_bnb.
package jam_pkg;
  typedef enum logic [2:0] {IDLE, ACC, CMP, PIVOT, SWAP, REV, DONE} state_e;
  localparam int MAXN = 8;
  localparam int MAXIW = 3;
  typedef logic [MAXN*MAXIW-1:0] permv_t;
  function automatic int iw_of(int n);
    return $clog2(n);
  endfunction
  function automatic int sw_of(int cw, int n);
    return cw + $clog2(n);
  endfunction
  // Element widths vary with N, so elements are built and read bit by bit.
  function automatic permv_t identity(int n, int iw);
    permv_t v;
    v = '0;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < iw; b++)
        v[w*iw+b] = w[b];
    return v;
  endfunction
  function automatic int elem(permv_t v, int iw, int i);
    int e;
    e = 0;
    for (int b = 0; b < iw; b++)
      e[b] = v[i*iw+b];
    return e;
  endfunction
  function automatic logic is_descending(permv_t v, int n, int iw);
    logic d;
    d = 1'b1;
    for (int i = 0; i < n - 1; i++)
      if (elem(v, iw, i) < elem(v, iw, i + 1)) d = 1'b0;
    return d;
  endfunction
endpackage

// File: rtl/jam_bnb_if.sv
// jam_bnb_if: cost-table lookup and search-result bus of jam_bnb.
interface jam_bnb_if import jam_pkg::*; #(
  parameter int N = 8,
  parameter int CW = 7,
  parameter int MCW = 16
);
  localparam int IW = iw_of(N);
  localparam int SW = sw_of(CW, N);
  logic Start;
  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost;
  logic [SW-1:0] MinCost;
  logic [MCW-1:0] MatchCount;
  logic [N*IW-1:0] BestPerm;
  logic Busy;
  logic Valid;
  modport master (output Start, Cost, input W, J, MinCost, MatchCount, BestPerm, Busy, Valid);
  modport slave (input Start, Cost, output W, J, MinCost, MatchCount, BestPerm, Busy, Valid);
endinterface

// File: rtl/jam_perm_step.sv
// jam_perm_step: combinational pivot search, successor swap and suffix reversal for lexicographic stepping.
module jam_perm_step #(
  parameter int N = 8,
  parameter int IW = 3
) (
  input  logic [N*IW-1:0] perm_i,
  input  logic [IW-1:0]   p_i,
  output logic [IW-1:0]   pivot_o,
  output logic [N*IW-1:0] swapped_o,
  output logic [N*IW-1:0] reversed_o
);
  logic [IW-1:0] e [N];
  logic [IW-1:0] k;
  logic found;
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign e[i] = perm_i[i*IW +: IW];
  end
  always_comb begin
    pivot_o = '0;
    k = '0;
    found = 1'b0;
    swapped_o = perm_i;
    reversed_o = perm_i;
    for (int i = 0; i < N - 1; i++)
      if (e[i] < e[i+1]) pivot_o = IW'(i);
    for (int i = 0; i < N; i++)
      if (IW'(i) > p_i && e[i] > e[p_i] && (!found || e[i] < e[k])) begin
        k = IW'(i);
        found = 1'b1;
      end
    // Suffix after the pivot is descending, so mirroring it around its centre sorts it.
    for (int i = 0; i < N; i++) begin
      swapped_o[i*IW +: IW] = (IW'(i) == p_i) ? e[k] : (IW'(i) == k) ? e[p_i] : e[i];
      reversed_o[i*IW +: IW] = (IW'(i) > p_i) ? e[IW'(N + int'(p_i) - i)] : e[i];
    end
  end
endmodule

// File: rtl/jam_bnb.sv
// jam_bnb: exhaustive/branch-and-bound minimum-cost assignment search over all N! permutations.
module jam_bnb import jam_pkg::*; #(
  parameter int N = 8,
  parameter int CW = 7,
  parameter int MCW = 16,
  parameter int PRUNE = 1
) (
  input logic clk,
  input logic rst,
  jam_bnb_if.slave bus
);
  localparam int IW = iw_of(N);
  localparam int SW = sw_of(CW, N);
  localparam int PW = N * IW;
  localparam permv_t ID_FULL = identity(N, IW);
  localparam logic [PW-1:0] ID = ID_FULL[PW-1:0];
  state_e state_q, state_d;
  logic [PW-1:0] perm_q, perm_d, best_q, best_d, swapped, reversed;
  logic [IW-1:0] w_q, w_d, p_q, p_d, pivot;
  logic [SW-1:0] sum_q, sum_d, min_q, min_d, acc;
  logic [MCW-1:0] cnt_q, cnt_d;
  logic pruned_q, pruned_d, prune_hit, desc;
  jam_perm_step #(.N(N), .IW(IW)) u_step (
    .perm_i(perm_q), .p_i(p_q), .pivot_o(pivot), .swapped_o(swapped), .reversed_o(reversed)
  );
  assign acc = sum_q + SW'(bus.Cost);
  assign prune_hit = (PRUNE != 0) && (acc > min_q);
  assign desc = is_descending(permv_t'(perm_q), N, IW);
  always_comb begin
    state_d = state_q;
    perm_d = perm_q;
    best_d = best_q;
    w_d = w_q;
    p_d = p_q;
    sum_d = sum_q;
    min_d = min_q;
    cnt_d = cnt_q;
    pruned_d = pruned_q;
    case (state_q)
      IDLE, DONE: if (bus.Start) begin
        state_d = ACC;
        perm_d = ID;
        best_d = ID;
        w_d = '0;
        sum_d = '0;
        min_d = '1;
        cnt_d = '0;
        pruned_d = 1'b0;
      end
      ACC: begin
        sum_d = acc;
        w_d = w_q + IW'(1);
        if (w_q == IW'(N - 1) || prune_hit) begin
          state_d = CMP;
          w_d = '0;
          pruned_d = prune_hit;
        end
      end
      CMP: begin
        if (!pruned_q && sum_q < min_q) begin
          min_d = sum_q;
          cnt_d = MCW'(1);
          best_d = perm_q;
        end else if (!pruned_q && sum_q == min_q) cnt_d = (&cnt_q) ? cnt_q : cnt_q + MCW'(1);
        state_d = desc ? DONE : PIVOT;
      end
      PIVOT: begin
        p_d = pivot;
        state_d = SWAP;
      end
      SWAP: begin
        perm_d = swapped;
        state_d = REV;
      end
      REV: begin
        perm_d = reversed;
        sum_d = '0;
        w_d = '0;
        pruned_d = 1'b0;
        state_d = ACC;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      perm_q <= ID;
      best_q <= ID;
      w_q <= '0;
      p_q <= '0;
      sum_q <= '0;
      min_q <= '1;
      cnt_q <= '0;
      pruned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      perm_q <= perm_d;
      best_q <= best_d;
      w_q <= w_d;
      p_q <= p_d;
      sum_q <= sum_d;
      min_q <= min_d;
      cnt_q <= cnt_d;
      pruned_q <= pruned_d;
    end
  end
  assign bus.W = w_q;
  assign bus.J = perm_q[w_q*IW +: IW];
  assign bus.MinCost = min_q;
  assign bus.MatchCount = cnt_q;
  assign bus.BestPerm = best_q;
  assign bus.Busy = (state_q != IDLE) && (state_q != DONE);
  assign bus.Valid = (state_q == DONE);
endmodule
